// File: rtl/snn_img_sequencer.sv
// snn_img_sequencer: streams N_IMG images of T_STEPS spike vectors from a sync-read
// RAM into the SNN core. It counts output spikes per neuron, picks the winning
// neuron by argmax, and holds the result on the board LEDs for HOLD_CYC cycles.
//
// Handshake: a beat is a single-cycle valid_board pulse. ips is valid in that cycle
// and is held until the next beat. The core acknowledges each timestep with a
// single-cycle TU_incre pulse, and each acknowledgement releases the next beat.
// ram_data is trusted only one cycle after ram_addr moves. An acknowledgement that
// arrives before that point is kept as pending and served on the next ready cycle.
module snn_img_sequencer #(
    parameter int M        = 256,
    parameter int N        = 8,
    parameter int T_STEPS  = 500,
    parameter int N_IMG    = 2,
    parameter int HOLD_CYC = 50000,
    parameter int CNT_W    = 8,
    parameter int ADDR_W   = 16,
    localparam int WW = (N > 1) ? $clog2(N) : 1,
    localparam int IW = (N_IMG > 1) ? $clog2(N_IMG) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [M-1:0]      ram_data,
    output logic [M-1:0]      ips,
    output logic              valid_board,
    output logic              nxt_img,
    input  logic [N-1:0]      ops,
    input  logic              TU_incre,
    output logic [WW-1:0]     winner,
    output logic              winner_valid,
    output logic [IW-1:0]     img_idx,
    output logic              led_hold,
    output logic              led_done
);

    localparam int TW = $clog2(T_STEPS + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, FEED, SCAN, HOLD, DONE} state_t;

    state_t           state;
    logic             data_rdy;
    logic             pending;
    logic [TW-1:0]    beat_cnt;
    logic [TW-1:0]    tu_cnt;
    logic [HW-1:0]    hold_cnt;
    logic [WW-1:0]    scan_idx;
    logic [WW-1:0]    best_idx;
    logic [CNT_W-1:0] best_val;
    logic [CNT_W-1:0] cnt [N];

    logic beat_ok;
    logic pend_set;
    logic cand_gt;

    // Beat issue, pending capture and argmax compare decisions for this cycle
    always_comb begin
        beat_ok  = 1'b0;
        pend_set = 1'b0;
        cand_gt  = 1'b0;
        if (state == FEED && beat_cnt < TW'(T_STEPS)) begin
            beat_ok  = data_rdy && (beat_cnt == '0 || pending || TU_incre);
            pend_set = !data_rdy && TU_incre && beat_cnt != '0;
        end
        cand_gt = cnt[scan_idx] > best_val;
    end

    // Sequencer FSM with registered outputs, spike counters and argmax
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ram_addr     <= '0;
            ips          <= '0;
            valid_board  <= 1'b0;
            nxt_img      <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
            img_idx      <= '0;
            led_hold     <= 1'b0;
            led_done     <= 1'b0;
            data_rdy     <= 1'b0;
            pending      <= 1'b0;
            beat_cnt     <= '0;
            tu_cnt       <= '0;
            hold_cnt     <= '0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best_val     <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            valid_board <= 1'b0;
            nxt_img     <= 1'b0;
            data_rdy    <= 1'b1;
            if (!enable && state != IDLE) begin
                // Run switch off: abandon the run and return everything to its start values
                state        <= IDLE;
                ram_addr     <= '0;
                data_rdy     <= (ram_addr == '0);
                ips          <= '0;
                winner       <= '0;
                winner_valid <= 1'b0;
                img_idx      <= '0;
                led_hold     <= 1'b0;
                led_done     <= 1'b0;
                pending      <= 1'b0;
                beat_cnt     <= '0;
                tu_cnt       <= '0;
                hold_cnt     <= '0;
                for (int i = 0; i < N; i++) cnt[i] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) state <= FEED;
                    end
                    FEED: begin
                        if (beat_ok) begin
                            valid_board <= 1'b1;
                            ips         <= ram_data;
                            ram_addr    <= ram_addr + ADDR_W'(1);
                            data_rdy    <= 1'b0;
                            beat_cnt    <= beat_cnt + TW'(1);
                            pending     <= 1'b0;
                            if (beat_cnt == '0) begin
                                nxt_img      <= (img_idx != '0);
                                winner_valid <= 1'b0;
                            end
                        end else if (pend_set) begin
                            pending <= 1'b1;
                        end
                        if (TU_incre && tu_cnt < TW'(T_STEPS)) begin
                            tu_cnt <= tu_cnt + TW'(1);
                            for (int i = 0; i < N; i++) begin
                                if (ops[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
                            end
                        end
                        if (tu_cnt == TW'(T_STEPS)) begin
                            state    <= SCAN;
                            scan_idx <= '0;
                            best_idx <= '0;
                            best_val <= '0;
                        end
                    end
                    SCAN: begin
                        if (cand_gt) begin
                            best_idx <= scan_idx;
                            best_val <= cnt[scan_idx];
                        end
                        if (scan_idx == WW'(N - 1)) begin
                            winner       <= cand_gt ? scan_idx : best_idx;
                            winner_valid <= 1'b1;
                            led_hold     <= 1'b1;
                            hold_cnt     <= '0;
                            state        <= HOLD;
                        end else begin
                            scan_idx <= scan_idx + WW'(1);
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == HW'(HOLD_CYC - 1)) begin
                            led_hold <= 1'b0;
                            if (img_idx == IW'(N_IMG - 1)) begin
                                led_done <= 1'b1;
                                state    <= DONE;
                            end else begin
                                img_idx  <= img_idx + IW'(1);
                                beat_cnt <= '0;
                                tu_cnt   <= '0;
                                pending  <= 1'b0;
                                for (int i = 0; i < N; i++) cnt[i] <= '0;
                                state    <= FEED;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snn_img_sequencer.sv
// Bench for snn_img_sequencer. A reference core and a RAM drive the sequencer
// with random spike patterns and random acknowledgement delays. A spike-count
// model with saturation and argmax predicts each winner.
module tb_snn_img_sequencer;

    localparam int M    = 8;
    localparam int N    = 4;
    localparam int T    = 4;
    localparam int NI   = 2;
    localparam int HC   = 10;
    localparam int CW   = 2;
    localparam int AW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] ram_addr;
    logic [M-1:0]  ram_data;
    logic [M-1:0]  ips;
    logic          valid_board;
    logic          nxt_img;
    logic [N-1:0]  ops;
    logic          TU_incre;
    logic [1:0]    winner;
    logic          winner_valid;
    logic [0:0]    img_idx;
    logic          led_hold;
    logic          led_done;

    logic [M-1:0] mem [256];
    int           cnt_m [N];
    int           vb_total;
    int           nx_total;
    int           checks;
    int           errors;

    snn_img_sequencer #(
        .M(M), .N(N), .T_STEPS(T), .N_IMG(NI), .HOLD_CYC(HC), .CNT_W(CW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ram_addr(ram_addr),
        .ram_data(ram_data), .ips(ips), .valid_board(valid_board), .nxt_img(nxt_img),
        .ops(ops), .TU_incre(TU_incre), .winner(winner), .winner_valid(winner_valid),
        .img_idx(img_idx), .led_hold(led_hold), .led_done(led_done)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read RAM
    always @(posedge clk) ram_data <= mem[ram_addr];

    // Pulse counters sampled mid-cycle
    initial begin
        vb_total = 0;
        nx_total = 0;
        forever begin
            @(negedge clk);
            if (valid_board === 1'b1) vb_total++;
            if (nxt_img === 1'b1) nx_total++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        TU_incre = 1'b0;
        ops      = '0;
    endtask

    task automatic wait_beat(input int lim, output int c);
        c = 0;
        do begin
            step();
            c++;
        end while (valid_board !== 1'b1 && c < lim);
    endtask

    function automatic int model_argmax();
        int b;
        b = 0;
        for (int i = 1; i < N; i++) if (cnt_m[i] > cnt_m[b]) b = i;
        return b;
    endfunction

    // One image: dly<0 picks a random core latency per step; stop_at>=0 returns at that beat
    task automatic run_image(input int img, input int dly, input logic [N-1:0] pat,
                             input bit rnd, input int stop_at, input bit last,
                             input bit rst_hold);
        int c, d, n, vb0, nx0, exp_w;
        logic [N-1:0] o;
        for (int i = 0; i < N; i++) cnt_m[i] = 0;
        vb0 = vb_total;
        nx0 = nx_total;
        wait_beat(40, c);
        for (int k = 0; k < T; k++) begin
            chk("beat_seen", 64'(valid_board), 64'(1));
            chk("ips", 64'(ips), 64'(mem[img*T+k]));
            chk("ram_addr", 64'(ram_addr), 64'(img*T+k+1));
            chk("nxt_img", 64'(nxt_img), 64'(k == 0 && img > 0));
            chk("img_idx", 64'(img_idx), 64'(img));
            chk("wv_low_in_feed", 64'(winner_valid), 64'(0));
            if (k == stop_at) return;
            d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
            repeat (d) step();
            o = rnd ? N'($urandom) : pat;
            TU_incre = 1'b1;
            ops      = o;
            for (int i = 0; i < N; i++) if (o[i] && cnt_m[i] < CMAX) cnt_m[i]++;
            if (k < T - 1) begin
                wait_beat(20, c);
                chk("beat_gap", 64'(c), 64'((d == 0) ? 2 : 1));
            end else begin
                step();
            end
        end
        exp_w = model_argmax();
        n = 0;
        while (led_hold !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("hold_seen", 64'(led_hold), 64'(1));
        chk("winner", 64'(winner), 64'(exp_w));
        chk("wv_high", 64'(winner_valid), 64'(1));
        n = 0;
        while (led_hold === 1'b1 && n < 200) begin
            if (rst_hold && n == 3) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_rst_outs",
                    64'({ram_addr, ips, valid_board, nxt_img, winner, winner_valid, img_idx, led_done}),
                    64'(0));
                chk("async_rst_hold", 64'(led_hold), 64'(0));
                return;
            end
            if (n == 2) begin
                TU_incre = 1'b1;
                ops      = '1;
            end
            step();
            n++;
        end
        chk("hold_len", 64'(n), 64'(HC));
        chk("beats_total", 64'(vb_total - vb0), 64'(T));
        chk("nxt_total", 64'(nx_total - nx0), 64'(img > 0));
        if (last) begin
            chk("led_done", 64'(led_done), 64'(1));
            chk("winner_done", 64'(winner), 64'(exp_w));
            chk("wv_done", 64'(winner_valid), 64'(1));
        end else begin
            chk("wv_until_next", 64'(winner_valid), 64'(1));
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_addr"}, 64'(ram_addr), 64'(0));
        chk({tag, "_beat"}, 64'({valid_board, nxt_img}), 64'(0));
        chk({tag, "_wv"}, 64'(winner_valid), 64'(0));
        chk({tag, "_img"}, 64'(img_idx), 64'(0));
        chk({tag, "_leds"}, 64'({led_hold, led_done}), 64'(0));
        chk({tag, "_ips"}, 64'(ips), 64'(0));
    endtask

    // Directed sequence of runs
    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        TU_incre = 1'b0;
        ops      = '0;
        for (int i = 0; i < 256; i++) mem[i] = M'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        chk("reset_winner", 64'(winner), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check_idle("idle");

        // Normal run, fixed latency: winner 2 then tie 0/1 resolves to 0
        enable = 1'b1;
        run_image(0, 3, 4'b0100, 1'b0, -1, 1'b0, 1'b0);
        run_image(1, 3, 4'b0011, 1'b0, -1, 1'b1, 1'b0);
        repeat (3) step();
        chk("done_stays", 64'({led_done, winner_valid}), 64'(3));
        enable = 1'b0;
        step();
        check_idle("done_clear");

        // Saturating neuron 3 with zero-latency acks, then random image
        enable = 1'b1;
        run_image(0, 0, 4'b1000, 1'b0, -1, 1'b0, 1'b0);
        run_image(1, -1, 4'b0000, 1'b1, -1, 1'b1, 1'b0);
        enable = 1'b0;
        step();
        check_idle("run2_clear");

        // Abort in the middle of image 1
        enable = 1'b1;
        run_image(0, -1, 4'b0000, 1'b1, -1, 1'b0, 1'b0);
        run_image(1, 2, 4'b0000, 1'b1, 1, 1'b0, 1'b0);
        enable = 1'b0;
        step();
        check_idle("abort");
        step();
        check_idle("abort_stay");

        // Restart after abort, then reset during HOLD
        enable = 1'b1;
        run_image(0, -1, 4'b0000, 1'b1, -1, 1'b0, 1'b1);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step();
        check_idle("post_reset");

        // Fresh full run after reset
        enable = 1'b1;
        run_image(0, -1, 4'b0000, 1'b1, -1, 1'b0, 1'b0);
        run_image(1, -1, 4'b0000, 1'b1, -1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
